zeta_sched: RTL and testbench

ZETA_SCHED -- requirements
Module: zeta_sched

---
 rtl/zeta_sched.sv | 158 +++++++++++++++
 tb/tb_zeta_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zeta_sched.sv
// zeta_sched: stage / butterfly sequencer that issues per-port, per-stage
// zeta ROM addresses for an NTT datapath, with inter-stage drain gaps,
// stall backpressure and forward or inverse stage ordering.

`ifndef NTT_STAGE_CNT
`define NTT_STAGE_CNT 8
`endif

// state    | meaning
// ST_IDLE  | waiting for start; outputs quiet
// ST_RUN   | one address pair issued per unstalled cycle, k advances
// ST_GAP   | drain gap between stages, no issue, ignores stall
// ST_FLUSH | final zeta_valid emitted, done pulses, back to idle
module zeta_sched #(
  parameter int STAGE_GAP = 4
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  start,
  input  logic                                                  inverse,
  input  logic                                                  stall,
  output logic                                                  busy,
  output logic                                                  done,
  output logic [1:0][`NTT_STAGE_CNT-1:0][`NTT_STAGE_CNT-2:0]   rom_addr,
  output logic [$clog2(`NTT_STAGE_CNT)-1:0]                     stage,
  output logic                                                  zeta_valid
);

  localparam int S  = `NTT_STAGE_CNT;
  localparam int AW = S - 1;          // address width, also butterfly index width
  localparam int KW = S - 2;          // issue counter width, C = 2^(S-2)
  localparam int SW = $clog2(S);

  localparam logic [KW-1:0] K_LAST   = '1;
  localparam logic [SW-1:0] STG_LAST = SW'(S - 1);
  // Gap counter is a down-counter loaded with STAGE_GAP-1 and left at zero.
  localparam logic [3:0]    GAP_LD   = 4'((STAGE_GAP == 0) ? 0 : STAGE_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GAP   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t                     state, state_n;
  logic [KW-1:0]              k, k_n;
  logic [SW-1:0]              stage_n;
  logic [SW-1:0]              stage_adv;
  logic [3:0]                 gap_cnt, gap_n;
  logic                       inv, inv_n;
  logic                       issue;
  logic                       last_stage;
  logic [1:0][S-1:0][AW-1:0]  rom_n;

  // Butterfly j = {k, port}; the stage-s twiddle index is the top s bits of j.
  function automatic logic [AW-1:0] zeta_addr(input logic [SW-1:0] s,
                                              input logic [KW-1:0] kk,
                                              input logic          port);
    logic [AW-1:0] j;
    logic [AW-1:0] mask;
    j = {kk, port};
    for (int b = 0; b < AW; b++) begin
      mask[b] = (b < int'(s));
    end
    return (j >> (AW - int'(s))) & mask;
  endfunction

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_FLUSH);
  assign issue      = (state == ST_RUN) && !stall;
  assign last_stage = inv ? (stage == '0) : (stage == STG_LAST);
  assign stage_adv  = inv ? (stage - SW'(1)) : (stage + SW'(1));

  // Next-state, counter and next-address computation.
  always_comb begin
    state_n = state;
    k_n     = k;
    stage_n = stage;
    gap_n   = gap_cnt;
    inv_n   = inv;
    rom_n   = '0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_n = ST_RUN;
          inv_n   = inverse;
          stage_n = inverse ? STG_LAST : '0;
          k_n     = '0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (k == K_LAST) begin
            if (last_stage) begin
              state_n = ST_FLUSH;
            end else if (STAGE_GAP == 0) begin
              stage_n = stage_adv;
              k_n     = '0;
            end else begin
              state_n = ST_GAP;
              gap_n   = GAP_LD;
            end
          end else begin
            k_n = k + KW'(1);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          state_n = ST_RUN;
          stage_n = stage_adv;
          k_n     = '0;
        end else begin
          gap_n = gap_cnt - 4'd1;
        end
      end
      ST_FLUSH: begin
        state_n = ST_IDLE;
        k_n     = '0;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // Address register presents the pair for the upcoming RUN cycle so the
    // ROM word is ready one cycle later, aligned with zeta_valid.
    if (state_n == ST_RUN) begin
      for (int p = 0; p < 2; p++) begin
        rom_n[p][stage_n] = zeta_addr(stage_n, k_n, 1'(p));
      end
    end
  end

  // State, counters, address and valid registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      k          <= '0;
      stage      <= '0;
      gap_cnt    <= '0;
      inv        <= 1'b0;
      zeta_valid <= 1'b0;
      rom_addr   <= '0;
    end else begin
      state      <= state_n;
      k          <= k_n;
      stage      <= stage_n;
      gap_cnt    <= gap_n;
      inv        <= inv_n;
      zeta_valid <= issue;
      rom_addr   <= rom_n;
    end
  end

endmodule

// File: tb/tb_zeta_sched.sv
// tb_zeta_sched: directed + randomized bench for zeta_sched with a slot-queue
// reference model of the stage schedule.
module tb_zeta_sched;

  localparam int S  = 8;
  localparam int C  = 64;
  localparam int G  = 4;
  localparam int AW = S - 1;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic inverse = 1'b0;
  logic stall = 1'b0;
  logic busy, done, zeta_valid;
  logic [1:0][S-1:0][AW-1:0] rom_addr;
  logic [SW-1:0] stage;

  logic start_z = 1'b0;
  logic stall_z = 1'b0;
  logic busy_z, done_z, zv_z;
  logic [1:0][S-1:0][AW-1:0] rom_z;
  logic [SW-1:0] stage_z;

  always #5 clk = ~clk;

  zeta_sched #(.STAGE_GAP(G)) u_dut (
    .clk(clk), .rst(rst), .start(start), .inverse(inverse), .stall(stall),
    .busy(busy), .done(done), .rom_addr(rom_addr), .stage(stage), .zeta_valid(zeta_valid)
  );

  zeta_sched #(.STAGE_GAP(0)) u_dut_g0 (
    .clk(clk), .rst(rst), .start(start_z), .inverse(1'b0), .stall(stall_z),
    .busy(busy_z), .done(done_z), .rom_addr(rom_z), .stage(stage_z), .zeta_valid(zv_z)
  );

  // Reference schedule: a queue of slots (0 = issue, 1 = gap, 2 = flush).
  typedef struct {
    int kind;
    int stg;
    int k;
  } slot_t;

  slot_t q[$];
  bit    active = 1'b0;
  bit    prev_issue = 1'b0;
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    zv_obs = 0;
  int    stall_hits = 0;
  int    obs_len = -1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0][S-1:0][AW-1:0] exp_rom(input int s, input int k);
    logic [1:0][S-1:0][AW-1:0] r;
    r = '0;
    for (int p = 0; p < 2; p++) begin
      r[p][s] = AW'(((2 * k + p) >> (S - 1 - s)) % (1 << s));
    end
    return r;
  endfunction

  task automatic build(input bit inv);
    int s;
    q.delete();
    for (int n = 0; n < S; n++) begin
      s = inv ? (S - 1 - n) : n;
      for (int k = 0; k < C; k++) q.push_back('{0, s, k});
      if (n < S - 1) begin
        for (int g = 0; g < G; g++) q.push_back('{1, s, 0});
      end
    end
    q.push_back('{2, 0, 0});
  endtask

  // One cycle: inputs already applied; check at negedge, then advance model.
  task automatic step();
    slot_t h;
    bit    cur_issue;
    @(negedge clk);
    if (zeta_valid === 1'b1) zv_obs++;
    if (done === 1'b1) obs_len = cyc - start_cyc;
    chk("zeta_valid", zeta_valid, prev_issue);
    if (!active) begin
      chk("busy_idle", busy, 0);
      chk("done_idle", done, 0);
    end else begin
      h = q[0];
      chk("busy", busy, 1);
      chk("done", done, h.kind == 2);
      if (h.kind == 0) begin
        chk("stage", stage, h.stg);
        chk("rom_addr", rom_addr, exp_rom(h.stg, h.k));
        if (h.stg == 7 && h.k == 5) begin
          chk("addr_s7k5_p0", rom_addr[0][7], 10);
          chk("addr_s7k5_p1", rom_addr[1][7], 11);
        end
        if (h.stg == 3 && h.k == 5) begin
          chk("addr_s3k5_p0", rom_addr[0][3], 0);
          chk("addr_s3k5_p1", rom_addr[1][3], 0);
        end
      end
    end
    cur_issue = active && (q[0].kind == 0) && !stall;
    if (rst) begin
      active = 1'b0;
      q.delete();
      prev_issue = 1'b0;
    end else begin
      prev_issue = cur_issue;
      if (!active) begin
        if (start) begin
          build(inverse);
          active = 1'b1;
          start_cyc = cyc;
        end
      end else if (q[0].kind == 0 && stall) begin
        stall_hits++;
      end else begin
        if (q[0].kind == 2) active = 1'b0;
        void'(q.pop_front());
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // mode: 0 no stall, 1 ten-cycle stall at stage 2 k 20, 2 random stall,
  // 3 reset in the gap after stage 4.
  task automatic run_xfer(input bit inv, input int mode, input string tag);
    int n;
    int dir_left;
    bit dir_used;
    inverse = inv;
    start = 1'b1;
    stall = 1'b0;
    zv_obs = 0;
    stall_hits = 0;
    obs_len = -1;
    step();
    start = 1'b0;
    n = 0;
    dir_left = 0;
    dir_used = 1'b0;
    while (active && n < 3000) begin
      n++;
      start = ($urandom_range(0, 15) == 0);
      inverse = 1'($urandom_range(0, 1));
      stall = 1'b0;
      if (mode == 1 && !dir_used && q[0].kind == 0 && q[0].stg == 2 && q[0].k == 20) begin
        dir_left = 10;
        dir_used = 1'b1;
      end
      if (dir_left > 0) begin
        stall = 1'b1;
        dir_left--;
      end
      if (mode == 2) stall = ($urandom_range(0, 3) == 0);
      if (mode == 3 && q[0].kind == 1 && q[0].stg == 4) rst = 1'b1;
      step();
      rst = 1'b0;
    end
    start = 1'b0;
    stall = 1'b0;
    chk({tag, "_terminated"}, active, 0);
    if (mode != 3) begin
      chk({tag, "_done_latency"}, obs_len, S * C + (S - 1) * G + 1 + stall_hits);
      chk({tag, "_valid_count"}, zv_obs, S * C);
    end
    if (mode == 1) begin
      chk({tag, "_stall_cycles"}, stall_hits, 10);
      chk({tag, "_done_delay"}, obs_len, 551);
    end
  endtask

  initial begin
    int n, zv_n, busy_n, first, last, done_at;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_stage", stage, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", zeta_valid, 0);
    step();
    rst = 1'b0;
    step();

    run_xfer(1'b0, 0, "fwd");
    run_xfer(1'b1, 0, "inv");
    run_xfer(1'b0, 1, "stall");
    run_xfer(1'($urandom_range(0, 1)), 2, "rnd0");
    run_xfer(1'($urandom_range(0, 1)), 2, "rnd1");

    run_xfer(1'b0, 3, "rst_gap");
    chk("rstgap_stage", stage, 0);
    chk("rstgap_rom_addr", rom_addr, 0);
    chk("rstgap_busy", busy, 0);
    chk("rstgap_done", done, 0);
    chk("rstgap_valid", zeta_valid, 0);
    step();
    run_xfer(1'b0, 0, "post_rst");

    start_z = 1'b1;
    @(posedge clk);
    #1;
    start_z = 1'b0;
    n = 0;
    zv_n = 0;
    busy_n = 0;
    first = -1;
    last = -1;
    done_at = -1;
    while (done_at < 0 && n < 2000) begin
      n++;
      start_z = (n == 100);
      @(negedge clk);
      if (zv_z === 1'b1) begin
        zv_n++;
        if (first < 0) first = n;
        last = n;
      end
      if (busy_z === 1'b1) busy_n++;
      if (done_z === 1'b1) done_at = n;
      if (n == 65) begin
        chk("g0_stage1_first", stage_z, 1);
        chk("g0_stage1_rom_p1", rom_z[1][1], 0);
      end
      @(posedge clk);
      #1;
    end
    start_z = 1'b0;
    chk("g0_done_latency", done_at, 513);
    chk("g0_valid_count", zv_n, 512);
    chk("g0_valid_contiguous", last - first + 1, 512);
    chk("g0_busy_cycles", busy_n, 513);
    @(negedge clk);
    chk("g0_idle_after_done", busy_z, 0);
    chk("g0_valid_after_done", zv_z, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
